// File: rtl/cpu_ififo_pkg.sv
// Shared constants for the instruction FIFO and decode: parcel/word widths,
// the set of opcodes that carry a 32-bit immediate, and length codes.
// Pure definitions; no state.
package cpu_ififo_pkg;

  localparam int PARCEL_W = 16;
  localparam int FETCH_W  = 32;

  // Instruction lengths in parcels
  localparam int LEN_SHORT = 1;
  localparam int LEN_LONG  = 3;

  // Opcode bytes (outside the 2'b11 form group) that take a 32-bit immediate
  localparam int NUM_LONG_OPS = 19;
  localparam logic [NUM_LONG_OPS*8-1:0] LONG_OPS = {
    8'h01, 8'h03, 8'h08, 8'h09, 8'h0c, 8'h0d, 8'h1a, 8'h1b, 8'h1d, 8'h1f,
    8'h20, 8'h22, 8'h24, 8'h25, 8'h30, 8'h36, 8'h37, 8'h38, 8'h39
  };

  // True when the opcode byte starts a 48-bit instruction
  function automatic logic insn_is_long(input logic [7:0] op);
    logic hit;
    hit = (op[7:6] == 2'b11);
    for (int i = 0; i < NUM_LONG_OPS; i++) begin
      if (LONG_OPS[i*8 +: 8] == op) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/cpu_insn_len.sv
// Instruction length decode: opcode byte in, 48-bit flag out.
// Latency: combinational.
// Backpressure: none.
module cpu_insn_len
  import cpu_ififo_pkg::*;
(
  input  logic [7:0] op,
  output logic       is_long
);

  // Membership test against the long-opcode set
  always_comb is_long = insn_is_long(op);

endmodule

// File: rtl/cpu_ififo.sv
// Fetch-word to instruction FIFO: 32-bit words split into 16-bit parcels,
// whole 16/48-bit instructions presented with their PC.
// Latency: word written into empty FIFO appears one edge later; full_o drops words (sticky overflow_o).
module cpu_ififo_param
  import cpu_ififo_pkg::*;
#(
  parameter int          DEPTH_LOG2   = 3,
  parameter logic [31:0] BOOT_ADDRESS = 32'h00001000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [31:0]           newPC_i,
  input  logic                  write_en_i,
  input  logic [FETCH_W-1:0]    data_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o,
  input  logic                  read_en_i,
  output logic                  valid_o,
  output logic [PARCEL_W-1:0]   opcode_o,
  output logic [31:0]           operand_o,
  output logic                  long_o,
  output logic [31:0]           PC_o,
  output logic                  overflow_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [CW-1:0]         cnt_t;

  logic [PARCEL_W-1:0] mem [DEPTH];
  ptr_t                rd_ptr, wr_ptr;
  ptr_t                rd_ptr1, rd_ptr2, wr_ptr1;
  cnt_t                count;
  logic [31:0]         pc_q;
  logic                drop_q;

  logic [PARCEL_W-1:0] head;
  logic                head_long;
  logic                slot_free, do_load, wr_acc;
  cnt_t                need, wr_num, rd_num;

  // Parcel indices wrap naturally at the pointer width
  assign rd_ptr1 = rd_ptr + ptr_t'(1);
  assign rd_ptr2 = rd_ptr + ptr_t'(2);
  assign wr_ptr1 = wr_ptr + ptr_t'(1);
  assign head    = mem[rd_ptr];

  cpu_insn_len u_len (
    .op      (head[15:8]),
    .is_long (head_long)
  );

  // Keep two free slots so a full word can always be accepted
  assign full_o  = (count > cnt_t'(DEPTH - 2));
  assign empty_o = (count == '0);
  assign count_o = count;

  // Load uses count from before this edge's write: no write-to-output bypass
  assign need      = head_long ? cnt_t'(LEN_LONG) : cnt_t'(LEN_SHORT);
  assign slot_free = !valid_o || read_en_i;
  assign do_load   = slot_free && (count >= need);
  assign wr_acc    = write_en_i && !full_o;
  assign wr_num    = !wr_acc ? cnt_t'(0) : (drop_q ? cnt_t'(1) : cnt_t'(2));
  assign rd_num    = do_load ? need : cnt_t'(0);

  // Parcel storage; the earlier parcel of a word lands first
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && wr_acc) begin
      if (drop_q) begin
        mem[wr_ptr] <= data_i[15:0];
      end else begin
        mem[wr_ptr]  <= data_i[31:16];
        mem[wr_ptr1] <= data_i[15:0];
      end
    end
  end

  // Pointers, occupancy, fetch PC and the registered instruction output
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      pc_q       <= BOOT_ADDRESS;
      drop_q     <= 1'b0;
      valid_o    <= 1'b0;
      opcode_o   <= '0;
      operand_o  <= '0;
      long_o     <= 1'b0;
      PC_o       <= BOOT_ADDRESS;
      overflow_o <= 1'b0;
    end else if (flush_i) begin
      // Redirect: a target at bit1=1 means the first parcel of the next word is skipped
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      valid_o <= 1'b0;
      pc_q    <= {newPC_i[31:1], 1'b0};
      drop_q  <= newPC_i[1];
    end else begin
      if (write_en_i && full_o) overflow_o <= 1'b1;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ptr_t'(wr_num);
        drop_q <= 1'b0;
      end
      if (do_load) rd_ptr <= rd_ptr + ptr_t'(rd_num);
      count <= count + wr_num - rd_num;

      if (slot_free) begin
        if (do_load) begin
          valid_o   <= 1'b1;
          opcode_o  <= head;
          operand_o <= head_long ? {mem[rd_ptr1], mem[rd_ptr2]} : 32'h0;
          long_o    <= head_long;
          PC_o      <= pc_q;
          pc_q      <= pc_q + (head_long ? 32'd6 : 32'd2);
        end else begin
          valid_o <= 1'b0;
        end
      end
    end
  end

endmodule
